mat_vec_result_serializer: RTL and testbench
============================================

Name: mat_vec_result_serializer

Overview:
- Consumer-side companion to the pipelined matrix-vector multiplier.
- Accepts one full parallel result vector of Ndata elements, each 2*Nbits wide, through a valid/ready handshake.
- Streams the elements out one per accepted beat, with an element index and a last flag, to a narrow downstream sink (memory writer, UART bridge, checker).
- Holds one vector at a time and can accept the next vector on the same cycle the last element leaves, so a continuously-ready sink sees no bubbles.

Parameters:
- Ndata, 4, number of elements per result vector (>=1).
- Nbits, 4, operand width of the multiplier; each result element is 2*Nbits bits.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_vec is valid this cycle.
- in_ready  output  1  block can capture in_vec this cycle.
- in_vec  input  Ndata*2*Nbits  packed result vector; element k = in_vec[(k+1)*2*Nbits-1 : k*2*Nbits].
- out_valid  output  1  out_data, out_idx and out_last are valid.
- out_ready  input  1  sink accepts the current element.
- out_data  output  2*Nbits  current element.
- out_idx  output  max(1,clog2(Ndata))  index k of the current element.
- out_last  output  1  high when out_idx == Ndata-1.

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, holding register=0, element counter=0, out_valid=0, out_data=0, out_idx=0, out_last=0. in_ready is 1 in the first cycle after reset is released.
- Handshakes: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- FSM state IDLE:
  - out_valid=0, in_ready=1.
  - On an input transfer: capture in_vec into the holding register, clear the counter, go to SEND.
- FSM state SEND:
  - out_valid=1. out_data is element[counter], out_idx=counter, out_last=(counter==Ndata-1).
  - On an output transfer with out_last=0: increment the counter.
  - On an output transfer with out_last=1: if in_valid, capture the new vector, clear the counter and stay in SEND; otherwise go to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is combinational from out_ready. No combinational path exists from in_valid to out_*.
- Latency: a vector accepted at edge T presents element 0 with out_valid=1 after edge T. With out_ready held high, the Ndata elements appear on Ndata consecutive cycles, and the next vector's element 0 follows immediately.
- Backpressure: while out_ready=0, out_data, out_idx and out_last hold stable and out_valid stays 1. A valid output is never withdrawn except by reset.
- in_vec is sampled only on an input transfer. Later changes to in_vec do not affect the vector being streamed.
- Ndata==1: every element is last. in_ready = IDLE || (out_valid && out_ready).
- Reset mid-stream: the remaining elements are discarded. out_valid=0 in the cycle after the reset edge, and the block returns to IDLE.
- Simultaneous reset and in_valid: reset wins and nothing is captured.
- No arithmetic on the data: elements pass bit-exact. The counter wraps only by being cleared on a new capture; it never counts past Ndata-1.

Decomposition:
- Shared package, matmul_pkg:
  - localparam ELEM_W = 2*Nbits;
  - localparam IDX_W = max(1,clog2(Ndata));
  - element-slice helper function, also used by the multiplier and loader blocks.
- No sub-module. The FSM, counter and element mux fit in one module; the mux is an indexed part-select on the holding register.

Test Plan:
- Basic stream:
  - Stimulus: after reset, in_vec=32'h0E0E_0D19 (Ndata=4, Nbits=4; this is the product of rows {5,6,7,1},{4,3,2,1},{4,5,0,0},{1,3,5,2} with X={1,2,1,1}), in_valid one cycle, out_ready=1.
  - Required: out_data 0x19,0x0D,0x0E,0x0E on 4 consecutive cycles, out_idx 0..3, out_last only on 0x0E at idx 3, then out_valid=0.
- Backpressure:
  - Stimulus: same vector, out_ready low on cycles 2-4 after capture.
  - Required: 0x0D held with idx=1 and out_valid=1 throughout the stall; order and values unchanged; total 7 cycles with out_valid=1.
- Back-to-back:
  - Stimulus: vectors A=32'h0E0E_0D19 then B=32'h0102_0304 with in_valid held, out_ready=1.
  - Required: in_ready=1 only on the idx=3 cycle of A; 8 consecutive elements 19,0D,0E,0E,04,03,02,01 with no gap.
- Input isolation:
  - Stimulus: change in_vec to 32'hFFFF_FFFF one cycle after capture.
  - Required: the stream still outputs 19,0D,0E,0E.
- Reset mid-stream:
  - Stimulus: assert reset while idx=2 is presented.
  - Required: next cycle out_valid=0, out_idx=0, out_data=0, in_ready=1; a new vector then streams from idx 0.
- Ndata=1 build:
  - Stimulus: in_vec=8'hA5 twice back-to-back.
  - Required: two beats of 0xA5, each with out_last=1 and idx=0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-vector multiplier family (multiplier, loader, serializer).
// Contents:
//   NBITS / NDATA   default operand width and vector length of the family
//   ELEM_W / IDX_W  default result-element width and element-index width
//   ser_state_e     serializer FSM states
//   idx_width()     max(1, clog2(n)) so a one-element vector still gets a 1-bit index
//   elem_lsb()      bit offset of element k in a packed vector
package matmul_pkg;

   localparam int unsigned NBITS  = 4;
   localparam int unsigned NDATA  = 4;
   localparam int unsigned ELEM_W = 2 * NBITS;
   localparam int unsigned IDX_W  = (NDATA > 1) ? $clog2(NDATA) : 1;

   typedef enum logic {
      StIdle,
      StSend
   } ser_state_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned elem_lsb(input int unsigned k, input int unsigned elem_w);
      return k * elem_w;
   endfunction

endpackage

// File: rtl/mat_vec_result_serializer.sv
// Takes one packed result vector of Ndata elements (2*Nbits bits each) over a valid/ready
// handshake and streams its elements out one per accepted beat, with index and last flag.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready also rises on the final output beat
//   in_vec                packed vector, element k at bits [(k+1)*ElemW-1 : k*ElemW]
//   out_valid / out_ready output handshake
//   out_data, out_idx     current element and its index (all outputs are registered)
//   out_last              high on the element with index Ndata-1
module mat_vec_result_serializer
   import matmul_pkg::*;
#(
   parameter int unsigned Ndata = 4,
   parameter int unsigned Nbits = 4,
   localparam int unsigned ElemW = 2 * Nbits,
   localparam int unsigned IdxW  = idx_width(Ndata),
   localparam int unsigned VecW  = Ndata * ElemW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [VecW-1:0]  in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ElemW-1:0] out_data,
   output logic [IdxW-1:0]  out_idx,
   output logic             out_last
);

   localparam logic [IdxW-1:0] LastIdx = IdxW'(Ndata - 1);

   ser_state_e       state_q, state_d;
   logic [VecW-1:0]  hold_q, hold_d;
   logic [IdxW-1:0]  cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [ElemW-1:0] out_data_q, out_data_d;
   logic [IdxW-1:0]  out_idx_q, out_idx_d;
   logic             out_last_q, out_last_d;

   logic out_xfer;
   logic in_xfer;

   assign out_xfer = out_valid_q && out_ready;
   // Accepting on the final beat lets a new vector follow with no bubble.
   assign in_ready = (state_q == StIdle) || (out_xfer && out_last_q);
   assign in_xfer  = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;

      if (in_xfer) begin
         hold_d  = in_vec;
         cnt_d   = '0;
         state_d = StSend;
      end else if (state_q == StSend && out_xfer) begin
         if (out_last_q) begin
            state_d = StIdle;
         end else begin
            cnt_d = cnt_q + IdxW'(1);
         end
      end

      // Outputs are registered, so they are computed from the next state and counter.
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_idx_d   = '0;
      out_last_d  = 1'b0;
      if (state_d == StSend) begin
         out_valid_d = 1'b1;
         out_data_d  = hold_d[elem_lsb(32'(cnt_d), ElemW) +: ElemW];
         out_idx_d   = cnt_d;
         out_last_d  = (cnt_d == LastIdx);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         hold_q      <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_mat_vec_result_serializer.sv
// Bench for mat_vec_result_serializer: a 4-element build and a 1-element build run side by
// side on shared handshake stimulus. The reference model is a queue of pending elements per
// build; an input transfer appends all elements of the vector, an output transfer pops one.
module tb_mat_vec_result_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_vec;
   logic [7:0]  in_vec1;

   logic        in_ready,  out_valid,  out_last;
   logic [7:0]  out_data;
   logic [1:0]  out_idx;
   logic        in_ready1, out_valid1, out_last1;
   logic [7:0]  out_data1;
   logic [0:0]  out_idx1;

   int checks   = 0;
   int failures = 0;
   bit after_reset = 1'b0;

   typedef struct {
      logic [7:0]  data;
      int unsigned idx;
      logic        last;
   } elem_t;

   elem_t q4[$];
   elem_t q1[$];

   always #5 clk = ~clk;

   mat_vec_result_serializer #(.Ndata(4), .Nbits(4)) u_dut4 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last)
   );

   mat_vec_result_serializer #(.Ndata(1), .Nbits(4)) u_dut1 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready1),
      .in_vec    (in_vec1),
      .out_valid (out_valid1),
      .out_ready (out_ready),
      .out_data  (out_data1),
      .out_idx   (out_idx1),
      .out_last  (out_last1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive at the falling edge, compare 1 time unit later, advance the
   // model on the rising edge.
   task automatic cycle(input logic rst, input logic iv, input logic [31:0] vec,
                        input logic ordy);
      logic        exp_rdy4, exp_rdy1;
      logic [31:0] v;
      @(negedge clk);
      reset     = rst;
      in_valid  = iv;
      in_vec    = vec;
      in_vec1   = vec[7:0];
      out_ready = ordy;
      #1;
      exp_rdy4 = (q4.size() == 0) || (q4.size() == 1 && ordy);
      exp_rdy1 = (q1.size() == 0) || (q1.size() == 1 && ordy);

      check("n4_in_ready", 32'(in_ready), 32'(exp_rdy4));
      check("n4_out_valid", 32'(out_valid), 32'(q4.size() != 0));
      if (q4.size() != 0) begin
         check("n4_out_data", 32'(out_data), 32'(q4[0].data));
         check("n4_out_idx", 32'(out_idx), q4[0].idx);
         check("n4_out_last", 32'(out_last), 32'(q4[0].last));
      end
      check("n1_in_ready", 32'(in_ready1), 32'(exp_rdy1));
      check("n1_out_valid", 32'(out_valid1), 32'(q1.size() != 0));
      if (q1.size() != 0) begin
         check("n1_out_data", 32'(out_data1), 32'(q1[0].data));
         check("n1_out_idx", 32'(out_idx1), q1[0].idx);
         check("n1_out_last", 32'(out_last1), 32'(q1[0].last));
      end
      if (after_reset) begin
         check("n4_rst_data", 32'(out_data), 32'h0);
         check("n4_rst_idx", 32'(out_idx), 32'h0);
         check("n4_rst_last", 32'(out_last), 32'h0);
         check("n1_rst_data", 32'(out_data1), 32'h0);
         check("n1_rst_last", 32'(out_last1), 32'h0);
      end

      @(posedge clk);
      after_reset = rst;
      if (rst) begin
         q4.delete();
         q1.delete();
      end else begin
         if (q4.size() != 0 && ordy) void'(q4.pop_front());
         if (q1.size() != 0 && ordy) void'(q1.pop_front());
         v = vec;
         if (iv && exp_rdy4) begin
            for (int k = 0; k < 4; k++) q4.push_back('{v[k*8 +: 8], k, (k == 3)});
         end
         if (iv && exp_rdy1) q1.push_back('{v[7:0], 0, 1'b1});
      end
   endtask

   localparam logic [31:0] VecA = 32'h0E0E_0D19;
   localparam logic [31:0] VecB = 32'h0102_0304;

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_vec    = '0;
      in_vec1   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);

      // Reset release: outputs at reset values, in_ready high.
      cycle(1'b1, 1'b0, 32'h0, 1'b1);

      // Basic stream.
      cycle(1'b0, 1'b1, VecA, 1'b1);
      repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1);

      // Backpressure: out_ready low on cycles 2-4 after capture.
      cycle(1'b0, 1'b1, VecA, 1'b1);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);

      // Back-to-back: in_valid held across A then B.
      repeat (4) cycle(1'b0, 1'b1, VecA, 1'b1);
      repeat (4) cycle(1'b0, 1'b1, VecB, 1'b1);
      repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1);

      // Input isolation: in_vec changes right after capture.
      cycle(1'b0, 1'b1, VecA, 1'b1);
      repeat (5) cycle(1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);

      // Reset while idx=2 is presented, then a fresh vector.
      cycle(1'b0, 1'b1, VecA, 1'b1);
      repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1);
      cycle(1'b1, 1'b1, VecB, 1'b1);
      cycle(1'b0, 1'b1, VecB, 1'b1);
      repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1);

      // One-element build sees 0xA5 twice back-to-back.
      repeat (2) cycle(1'b0, 1'b1, 32'h0000_00A5, 1'b1);
      repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(63) == 0), ($urandom_range(1) == 1), $urandom,
               ($urandom_range(3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
